// File: rtl/mac_pkg.sv
// Shared definitions for the multiplier / MAC datapath: default widths,
// FSM state encoding and the counter-width helper.
package mac_pkg;

    localparam int PROD_W_DEF    = 8;
    localparam int ACC_W_DEF     = 16;
    localparam int MAX_TERMS_DEF = 16;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_ACCUM = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Bits needed to hold every value 0..max_terms inclusive.
    function automatic int cnt_width(input int max_terms);
        return $clog2(max_terms + 1);
    endfunction

endpackage

// File: rtl/product_accumulator_term_counter.sv
// Term counter for the accumulator: loads a limit and clears the count,
// increments on enable, and flags when the current term is the last one.
module term_counter #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_limit,
    input  logic             i_en,
    output logic             o_last
);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] r_limit;
    logic [CNT_W-1:0] w_count_inc;

    assign w_count_inc = r_count + CNT_W'(1);
    // Compare count+1 against the limit so the flag is valid during the final transfer.
    assign o_last      = (w_count_inc == r_limit);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_limit <= '0;
        end else if (i_load) begin
            r_count <= '0;
            r_limit <= i_limit;
        end else if (i_en) begin
            r_count <= w_count_inc;
        end
    end

endmodule

// File: rtl/product_accumulator.sv
// MAC back end: sums a run of unsigned products accepted over valid/ready and
// presents the total on a valid/ready result port with a sticky overflow flag.
module product_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int ACC_W     = ACC_W_DEF,
    parameter int MAX_TERMS = MAX_TERMS_DEF,
    parameter int CNT_W     = cnt_width(MAX_TERMS_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_terms,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [PROD_W-1:0] i_product,
    output logic [ACC_W-1:0]  o_acc_out,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic              o_busy,
    output logic              o_overflow
);

    localparam logic [CNT_W-1:0] LP_MAX_TERMS = CNT_W'(MAX_TERMS);

    logic [1:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;

    logic             w_arm;
    logic             w_xfer;
    logic             w_last;
    logic [CNT_W-1:0] w_limit;
    logic [ACC_W:0]   w_sum;

    assign w_arm   = (r_state == ST_IDLE) && i_start;
    assign w_xfer  = (r_state == ST_ACCUM) && i_in_valid;
    assign w_limit = (i_num_terms > LP_MAX_TERMS) ? LP_MAX_TERMS : i_num_terms;
    // One extra bit captures the carry out of the accumulator for the overflow flag.
    assign w_sum   = {1'b0, r_acc} + (ACC_W + 1)'(i_product);

    term_counter #(
        .CNT_W (CNT_W)
    ) u_term_counter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_arm),
        .i_limit (w_limit),
        .i_en    (w_xfer),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_acc   <= '0;
                        r_ovf   <= 1'b0;
                        r_state <= (w_limit == '0) ? ST_DONE : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (w_xfer) begin
                        r_acc <= w_sum[ACC_W-1:0];
                        r_ovf <= r_ovf | w_sum[ACC_W];
                        if (w_last) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (i_out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_in_ready  = (r_state == ST_ACCUM);
    assign o_out_valid = (r_state == ST_DONE);
    assign o_busy      = (r_state == ST_ACCUM) || (r_state == ST_DONE);
    assign o_acc_out   = r_acc;
    assign o_overflow  = r_ovf;

endmodule
